// File: rtl/console_pkg.sv
// console_pkg: rate codes, tick periods and scheduler state encoding shared across the console sampling path
package console_pkg;
  localparam logic [3:0] FSAMP_1K = 4'h1;
  localparam logic [3:0] FSAMP_2K = 4'h2;
  localparam logic [3:0] FSAMP_4K = 4'h3;
  localparam logic [3:0] FSAMP_8K = 4'h4;
  localparam logic [3:0] FSAMP_16K = 4'h5;
  // Tick periods in clk cycles for a 100 MHz system clock
  localparam int TICK_1K = 100000;
  localparam int TICK_2K = 50000;
  localparam int TICK_4K = 25000;
  localparam int TICK_8K = 12500;
  localparam int TICK_16K = 6250;
  typedef enum logic [2:0] {IDLE, ARM, WAIT, START, BUSY, PACK} state_t;
  function automatic logic [3:0] fsamp_sel(input logic [3:0] code);
    return (code >= FSAMP_1K && code <= FSAMP_16K) ? code : FSAMP_1K;
  endfunction
endpackage

// File: rtl/console_samp_sched.sv
// console_samp_sched: per-tick device conversion sequencer with overrun and timeout tracking
module console_samp_sched
  import console_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               work,
  input  logic [3:0]         freq_req,
  output logic [3:0]         freq_samp,
  input  logic               fs,
  output logic               fd,
  output logic [NUM_DEV-1:0] dev_start,
  input  logic [NUM_DEV-1:0] dev_done,
  output logic               pkt_valid,
  input  logic               pkt_ack,
  output logic [CNT_W-1:0]   samp_cnt,
  output logic [CNT_W-1:0]   ovr_cnt,
  output logic [NUM_DEV-1:0] err_tmo
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int IW = NUM_DEV > 1 ? $clog2(NUM_DEV) : 1;
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic fs_seen, live, tick, ovr, done, tmo, adv, last;
  // fs stays high until acknowledged; fs_seen blocks re-accepting the same level after fd
  always_comb begin
    live = state inside {WAIT, START, BUSY, PACK};
    tick = live && fs && !fd && !fs_seen;
    ovr = tick && state != WAIT;
    done = dev_done[idx];
    tmo = timer == TW'(TIMEOUT - 1);
    adv = state == BUSY && (done || tmo);
    last = idx == IW'(NUM_DEV - 1);
  end
  always_comb begin
    nxt = state;
    if (!work) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = ARM;
        ARM:     nxt = WAIT;
        WAIT:    nxt = tick ? START : WAIT;
        START:   nxt = BUSY;
        BUSY:    nxt = adv ? (last ? PACK : START) : BUSY;
        PACK:    nxt = pkt_ack ? ARM : PACK;
        default: nxt = IDLE;
      endcase
  end
  assign pkt_valid = state == PACK;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_samp <= FSAMP_1K;
      fd <= 1'b0;
      dev_start <= '0;
      samp_cnt <= '0;
      ovr_cnt <= '0;
      err_tmo <= '0;
      idx <= '0;
      timer <= '0;
      fs_seen <= 1'b0;
    end else begin
      fd <= work && tick;
      fs_seen <= fs && (fs_seen || (work && tick));
      dev_start <= (work && state == START) ? NUM_DEV'(1) << idx : '0;
      if (state != BUSY) timer <= '0;
      else if (!(&timer)) timer <= timer + 1'b1;
      if (state == IDLE && work) begin
        samp_cnt <= '0;
        ovr_cnt <= '0;
        err_tmo <= '0;
      end
      if (state == ARM) freq_samp <= fsamp_sel(freq_req);
      if (state == WAIT && tick) idx <= '0;
      if (adv && !last) idx <= idx + 1'b1;
      if (adv && !done) err_tmo[idx] <= 1'b1;
      if (work && state == PACK && pkt_ack) samp_cnt <= samp_cnt + 1'b1;
      if (work && ovr && !(&ovr_cnt)) ovr_cnt <= ovr_cnt + 1'b1;
    end
  end
endmodule
